// File: rtl/press_seq_pkg.sv
// Shared types and defaults for the press sequence generator.
package press_seq_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned TIM_W_DEF = 8;

    typedef enum logic [2:0] {
        StIdle,
        StHigh,
        StLow,
        StBounce,
        StDone
    } state_e;

endpackage

// File: rtl/press_phase_timer.sv
// Phase length down-counter: load len, then 'last' is high on the final cycle of the phase.
// A len of 0 is treated as 1, so a loaded phase always lasts max(len,1) cycles.
module press_phase_timer #(
    parameter int unsigned TIM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TIM_W-1:0] len,
    output logic             last
);

    logic [TIM_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= (len == '0) ? '0 : len - TIM_W'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TIM_W'(1);
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/press_seq_gen.sv
// Generates programmed trains of press pulses (n presses, hold high cycles, gap low cycles).
// Define PRESS_SEQ_GEN_BOUNCE_EN to precede every press with BOUNCE_PULSES one-cycle glitches.
module press_seq_gen
    import press_seq_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned TIM_W = TIM_W_DEF
`ifdef PRESS_SEQ_GEN_BOUNCE_EN
    ,
    parameter int unsigned BOUNCE_PULSES = 2
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_press,
    input  logic [TIM_W-1:0] hold,
    input  logic [TIM_W-1:0] gap,
    output logic             press,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent
);

`ifdef PRESS_SEQ_GEN_BOUNCE_EN
    localparam logic [TIM_W-1:0] BounceLen = TIM_W'(2 * BOUNCE_PULSES);
    localparam state_e StPress = StBounce;
`else
    localparam state_e StPress = StHigh;
`endif

    state_e           state_q;
    logic [CNT_W-1:0] n_q;
    logic [TIM_W-1:0] hold_q;
    logic [TIM_W-1:0] gap_q;

    logic             tmr_load;
    logic [TIM_W-1:0] tmr_len;
    logic             tmr_last;

    // Timer is reloaded on every phase entry; len picks the phase being entered.
    always_comb begin
        tmr_load = 1'b0;
        tmr_len  = hold_q;
        case (state_q)
            StIdle: begin
                if (start && (n_press != '0)) begin
                    tmr_load = 1'b1;
`ifdef PRESS_SEQ_GEN_BOUNCE_EN
                    tmr_len  = BounceLen;
`else
                    tmr_len  = hold;
`endif
                end
            end
            StHigh: begin
                if (tmr_last) begin
                    tmr_load = 1'b1;
                    tmr_len  = gap_q;
                end
            end
            StLow: begin
                if (tmr_last && (sent != n_q)) begin
                    tmr_load = 1'b1;
`ifdef PRESS_SEQ_GEN_BOUNCE_EN
                    tmr_len  = BounceLen;
`else
                    tmr_len  = hold_q;
`endif
                end
            end
`ifdef PRESS_SEQ_GEN_BOUNCE_EN
            StBounce: begin
                if (tmr_last) begin
                    tmr_load = 1'b1;
                    tmr_len  = hold_q;
                end
            end
`endif
            default: ;
        endcase
    end

    press_phase_timer #(
        .TIM_W (TIM_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .len  (tmr_len),
        .last (tmr_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            press   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sent    <= '0;
            n_q     <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        sent <= '0;
                        if (n_press != '0) begin
                            n_q     <= n_press;
                            hold_q  <= hold;
                            gap_q   <= gap;
                            busy    <= 1'b1;
                            press   <= 1'b1;
                            state_q <= StPress;
                        end else begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StHigh: begin
                    if (tmr_last) begin
                        press   <= 1'b0;
                        sent    <= sent + CNT_W'(1);
                        state_q <= StLow;
                    end
                end
                StLow: begin
                    if (tmr_last) begin
                        if (sent == n_q) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            press   <= 1'b1;
                            state_q <= StPress;
                        end
                    end
                end
`ifdef PRESS_SEQ_GEN_BOUNCE_EN
                // Glitches alternate 1/0; the phase always ends on a low cycle.
                StBounce: begin
                    if (tmr_last) begin
                        press   <= 1'b1;
                        state_q <= StHigh;
                    end else begin
                        press   <= ~press;
                    end
                end
`endif
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    press   <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_press_seq_gen.sv
// Scoreboard bench for press_seq_gen: per-cycle expectations are queued at start, compared each cycle.
module tb_press_seq_gen;

`ifdef PRESS_SEQ_GEN_BOUNCE_EN
    localparam int BP = 2;
`else
    localparam int BP = 0;
`endif

    typedef struct packed {
        logic       press;
        logic       busy;
        logic       done;
        logic [7:0] sent;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] n_press;
    logic [7:0] hold;
    logic [7:0] gap;
    logic       press;
    logic       busy;
    logic       done;
    logic [7:0] sent;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    always #5 clk = ~clk;

`ifdef PRESS_SEQ_GEN_BOUNCE_EN
    press_seq_gen #(.CNT_W(8), .TIM_W(8), .BOUNCE_PULSES(BP)) dut (
`else
    press_seq_gen #(.CNT_W(8), .TIM_W(8)) dut (
`endif
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .n_press (n_press),
        .hold    (hold),
        .gap     (gap),
        .press   (press),
        .busy    (busy),
        .done    (done),
        .sent    (sent)
    );

    // Expected outputs for each cycle following the accepting edge.
    task automatic push_seq(input int n, input int h, input int g);
        int hh = (h == 0) ? 1 : h;
        int gg = (g == 0) ? 1 : g;
        for (int k = 1; k <= n; k++) begin
            for (int j = 0; j < 2 * BP; j++) q.push_back('{(j % 2) == 0, 1'b1, 1'b0, 8'(k - 1)});
            for (int j = 0; j < hh; j++) q.push_back('{1'b1, 1'b1, 1'b0, 8'(k - 1)});
            for (int j = 0; j < gg; j++) q.push_back('{1'b0, 1'b1, 1'b0, 8'(k)});
        end
        q.push_back('{1'b0, 1'b0, 1'b1, 8'(n)});
        q.push_back('{1'b0, 1'b0, 1'b0, 8'(n)});
    endtask

    task automatic run_seq(input string name, input int n, input int h, input int g,
                           input int poke_at, input int abort_at, output int done_cnt);
        exp_t e;
        int   i = 0;
        done_cnt = 0;
        n_press  = 8'(n);
        hold     = 8'(h);
        gap      = 8'(g);
        start    = 1'b1;
        push_seq(n, h, g);
        @(posedge clk); #1;
        start   = 1'b0;
        n_press = 8'hAA;
        hold    = 8'h77;
        gap     = 8'h55;
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({press, busy, done, sent} !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got press=%b busy=%b done=%b sent=%0d, want press=%b busy=%b done=%b sent=%0d",
                         name, i, press, busy, done, sent, e.press, e.busy, e.done, e.sent);
            end
            if (done === 1'b1) done_cnt++;
            if (i == abort_at) begin
                q.delete();
                return;
            end
            if (i == poke_at) begin
                start   = 1'b1;
                n_press = 8'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            i++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b1;
        n_press = 8'd3;
        hold    = 8'd2;
        gap     = 8'd3;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({press, busy, done, sent} !== 11'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: got press=%b busy=%b done=%b sent=%0d, want all 0",
                         c, press, busy, done, sent);
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({press, busy, done, sent} !== 11'b0) begin
                errors++;
                $display("FAIL post_reset_idle cycle %0d: got press=%b busy=%b done=%b sent=%0d, want all 0",
                         c, press, busy, done, sent);
            end
        end
    endtask

    task automatic test_basic();
        int dc;
        run_seq("basic", 3, 2, 3, -1, -1, dc);
        checks++;
        if (dc !== 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d, want 1", dc);
        end
    endtask

    task automatic test_zero_args();
        int dc;
        run_seq("zero_n", 0, 5, 5, -1, -1, dc);
        run_seq("min_args", 1, 0, 0, -1, -1, dc);
        run_seq("max_hold", 1, 255, 1, -1, -1, dc);
    endtask

    task automatic test_ignore_busy();
        int dc;
        run_seq("ignore_busy", 3, 2, 3, 4, -1, dc);
        checks++;
        if (dc !== 1) begin
            errors++;
            $display("FAIL ignore_busy_done_count: got %0d, want 1", dc);
        end
    endtask

    task automatic test_reset_mid();
        int dc;
        run_seq("reset_mid", 5, 2, 2, -1, 4 * BP + 4, dc);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({press, busy, done, sent} !== 11'b0) begin
            errors++;
            $display("FAIL reset_mid_clear: got press=%b busy=%b done=%b sent=%0d, want all 0",
                     press, busy, done, sent);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({press, busy, done} !== 3'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet cycle %0d: got press=%b busy=%b done=%b, want 0 0 0",
                         c, press, busy, done);
            end
        end
        run_seq("after_reset", 2, 1, 2, -1, -1, dc);
    endtask

    task automatic test_back_to_back();
        int dc;
        run_seq("b2b_a", 2, 3, 1, -1, -1, dc);
        run_seq("b2b_b", 1, 1, 4, -1, -1, dc);
    endtask

`ifdef PRESS_SEQ_GEN_BOUNCE_EN
    task automatic test_bounce();
        int dc;
        run_seq("bounce", 1, 3, 1, -1, -1, dc);
    endtask
`endif

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        n_press = '0;
        hold    = '0;
        gap     = '0;
        test_reset();
        test_basic();
        test_zero_args();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
`ifdef PRESS_SEQ_GEN_BOUNCE_EN
        test_bounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/press_seq_gen.md
Name: press_seq_gen

Overview:
- Stimulus-side counterpart of the button-press FSM: generates programmed trains of `press` pulses on the FSM's `press` input.
- Software/testbench requests N presses with a given high time and low gap; the block sequences them, reports progress, and pulses `done`.
- Sits upstream of the press-counting FSM, on the same `clk`/`rst` domain.
- Replaces hand-written `#delay` stimulus with synthesizable, cycle-exact sequences.

Parameters:
- CNT_W, 8, width of press count fields (matches FSM count width).
- TIM_W, 8, width of hold/gap cycle fields.
- BOUNCE_PULSES, 2, number of glitch pulses per press (only with BOUNCE_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- n_press  input  CNT_W  presses to generate; latched on accepted start.
- hold  input  TIM_W  cycles press stays high; 0 treated as 1; latched on start.
- gap  input  TIM_W  low cycles after each press; 0 treated as 1; latched on start.
- press  output  1  registered press drive to FSM.
- busy  output  1  high from cycle after accepted start until the cycle done asserts.
- done  output  1  one-cycle completion pulse.
- sent  output  CNT_W  completed presses in current/last sequence.

Behaviour:
- Reset (sync, active-high, overrides all): press=0, busy=0, done=0, sent=0, state=IDLE, latched fields=0.
- States: IDLE, HIGH, LOW, DONE; plus BOUNCE with BOUNCE_EN.
- IDLE:
  - start=1 and n_press≠0: latch n_press/hold/gap, clear sent, go HIGH; press=1 and busy=1 from the next edge (latency 1).
  - start=1 and n_press=0: clear sent, go DONE; no press ever asserted.
- HIGH: press=1 for exactly max(hold,1) cycles. At the last HIGH cycle, sent increments (visible the next cycle), then go LOW.
- LOW: press=0 for exactly max(gap,1) cycles. Then:
  - sent==latched n → DONE.
  - otherwise → HIGH (or BOUNCE).
- DONE: exactly one cycle; done=1, busy=0, press=0. Next state IDLE. done is registered and never coincides with press=1.
- start while not in IDLE is ignored; it is not queued.
- Input changes after an accepted start do not affect the running sequence.
- sent holds its final value after DONE until the next accepted start or reset.
- sent cannot wrap: n_press ≤ 2^CNT_W−1 and the count stops at n.
- Phase timer loads max(x,1)−1 and counts down to 0; hold=255 gives 255 cycles with no overflow.
- Reset mid-sequence: press=0 at the next edge; no done pulse; state returns to IDLE.
- Total busy cycles for a sequence = n·(max(hold,1)+max(gap,1)), plus bounce cycles when enabled.

Optional Feature:
- Macro: PRESS_SEQ_GEN_BOUNCE_EN.
- Defined: before every HIGH phase, enter BOUNCE.
  - BOUNCE emits BOUNCE_PULSES 1-cycle press=1 glitches, each followed by 1 cycle press=0 (2·BOUNCE_PULSES cycles).
  - Then enter HIGH. Glitches do not increment sent.
  - Purpose: exercise the FSM's err counter.
- Undefined: BOUNCE state, its counter and the parameter's logic are absent; IDLE/LOW go directly to HIGH.

Decomposition:
- Package press_seq_pkg:
  - state enum typedef (IDLE, HIGH, LOW, BOUNCE, DONE).
  - localparams CNT_W_DEF=8, TIM_W_DEF=8.
- One sub-module, press_phase_timer:
  - TIM_W down-counter with load value max(x,1)−1.
  - Outputs a last-cycle flag.
  - Instantiated once and reused for HIGH, LOW and BOUNCE phases.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 → press=0, busy=0, done=0, sent=0 throughout; no sequence starts after release until a new start.
- Basic: n_press=3, hold=2, gap=3, single start pulse →
  - press pattern 110001100011000 starting 1 cycle after start.
  - done pulse on the cycle after the last low (15 busy cycles).
  - sent steps 1,2,3.
- Zero args: n_press=0 → done pulses 1 cycle after start, press never high, sent=0. Then n_press=1, hold=0, gap=0 → one 1-cycle press, 1-cycle low, done, sent=1.
- Ignore while busy: start again mid-sequence with n_press=9 → sequence unchanged, sent ends at 3, exactly one done pulse.
- Reset mid-op: rst=1 during 2nd HIGH of an n=5 sequence → press=0 and sent=0 next edge, no done; a following start runs a fresh sequence correctly.
- Bounce (PRESS_SEQ_GEN_BOUNCE_EN, BOUNCE_PULSES=2): n=1, hold=3, gap=1 → press pattern 1010111 then 0; done follows; sent=1.
